// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder for the XIP read path: decodes READ + 24-bit address,
// then streams 32-bit words fetched from a backing memory port, MSB first.
module spi_flash_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] READ_CMD    = 8'h03
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spi_sck,
    input  logic        spi_ss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [23:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        busy,
    output logic        underrun
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SYNC_N-1:0]   r_sck_sync;
    logic [SYNC_N-1:0]   r_ss_sync;
    logic [SYNC_N-1:0]   r_mosi_sync;
    logic                r_sck_prev;
    logic                r_ss_prev;
    logic [22:0]         r_rx;
    logic [4:0]          r_bit_cnt;
    logic [23:0]         r_addr;
    logic [31:0]         r_tx;
    logic                r_data_ready;
    logic                r_pending;
    logic                r_drop;
    logic                r_miso;
    logic                r_req_valid;
    logic [23:0]         r_req_addr;
    logic                r_busy;
    logic                r_underrun;

    logic                w_sck_s;
    logic                w_ss_s;
    logic                w_mosi_s;
    logic                w_ss_rise;
    logic                w_ss_fall;
    logic                w_sck_rise;
    logic                w_sck_fall;
    logic [23:0]         w_rx_next;
    logic [23:0]         w_addr_inc;
    logic                w_req_accept;

    assign w_sck_s      = r_sck_sync[SYNC_N-1];
    assign w_ss_s       = r_ss_sync[SYNC_N-1];
    assign w_mosi_s     = r_mosi_sync[SYNC_N-1];
    assign w_ss_rise    = w_ss_s & ~r_ss_prev;
    assign w_ss_fall    = ~w_ss_s & r_ss_prev;
    // Gating with synchronised SS drops sck edges that coincide with deselect.
    assign w_sck_rise   = w_sck_s & ~r_sck_prev & ~w_ss_s;
    assign w_sck_fall   = ~w_sck_s & r_sck_prev & ~w_ss_s;
    assign w_rx_next    = {r_rx, w_mosi_s};
    assign w_addr_inc   = r_addr + 24'd4;
    assign w_req_accept = r_req_valid & mem_req_ready;

    assign spi_miso      = r_miso;
    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_req_addr;
    assign busy          = r_busy;
    assign underrun      = r_underrun;

    // Pin synchronisers and previous-sample registers for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_prev  <= 1'b0;
            r_ss_prev   <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_N-2:0], spi_sck};
            r_ss_sync   <= {r_ss_sync[SYNC_N-2:0], spi_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_N-2:0], spi_mosi};
            r_sck_prev  <= w_sck_s;
            r_ss_prev   <= w_ss_s;
        end
    end

    // State register and registered busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_IDLE);
        end
    end

    // Next-state decode; SS edges override any protocol progress.
    always_comb begin
        w_state_next = r_state;
        if (w_ss_rise) begin
            w_state_next = ST_IDLE;
        end else if (w_ss_fall) begin
            w_state_next = ST_CMD;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (w_sck_rise && (r_bit_cnt == 5'd7)) begin
                        w_state_next = (w_rx_next[7:0] == READ_CMD) ? ST_ADDR : ST_IGNORE;
                    end else begin
                        w_state_next = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (w_sck_rise && (r_bit_cnt == 5'd31)) begin
                        w_state_next = ST_DATA;
                    end else begin
                        w_state_next = ST_ADDR;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // Shift registers, memory request/response handshake and MISO driver.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx         <= 23'd0;
            r_bit_cnt    <= 5'd0;
            r_addr       <= 24'd0;
            r_tx         <= 32'd0;
            r_data_ready <= 1'b0;
            r_pending    <= 1'b0;
            r_drop       <= 1'b0;
            r_miso       <= 1'b0;
            r_req_valid  <= 1'b0;
            r_req_addr   <= 24'd0;
            r_underrun   <= 1'b0;
        end else begin
            if (w_req_accept) begin
                r_req_valid <= 1'b0;
            end
            if (w_ss_rise) begin
                r_miso       <= 1'b0;
                r_req_valid  <= 1'b0;
                r_data_ready <= 1'b0;
            end else if (w_ss_fall) begin
                r_bit_cnt    <= 5'd0;
                r_underrun   <= 1'b0;
                r_rx         <= 23'd0;
                r_miso       <= 1'b0;
                r_data_ready <= 1'b0;
            end else begin
                case (r_state)
                    ST_CMD, ST_ADDR: begin
                        if (w_sck_rise) begin
                            r_rx      <= w_rx_next[22:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if ((r_state == ST_ADDR) && (r_bit_cnt == 5'd31)) begin
                                r_addr      <= {w_rx_next[23:2], 2'b00};
                                r_req_addr  <= {w_rx_next[23:2], 2'b00};
                                r_req_valid <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sck_fall) begin
                            if (r_data_ready) begin
                                r_miso <= r_tx[31];
                                r_tx   <= {r_tx[30:0], 1'b0};
                            end else begin
                                r_miso     <= 1'b0;
                                r_underrun <= 1'b1;
                            end
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd31) begin
                                r_addr       <= w_addr_inc;
                                r_req_addr   <= w_addr_inc;
                                r_req_valid  <= 1'b1;
                                r_data_ready <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            // A response to a request abandoned by deselect is swallowed via r_drop.
            if (w_req_accept) begin
                r_pending <= 1'b1;
                r_drop    <= w_ss_rise;
            end else if (mem_rsp_valid && r_pending) begin
                r_pending <= 1'b0;
                r_drop    <= 1'b0;
                if (!r_drop && !w_ss_rise && (r_state == ST_DATA)) begin
                    r_tx         <= mem_rsp_data;
                    r_data_ready <= 1'b1;
                end
            end else if (w_ss_rise && r_pending) begin
                r_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: SPI master driver, memory model that
// checks request addresses, and a MISO monitor that pops expected bits.
module tb_spi_flash_responder;

    localparam int HALF = 12;

    logic        clock;
    logic        reset;
    logic        spi_sck;
    logic        spi_ss;
    logic        spi_mosi;
    logic        spi_miso;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [23:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        busy;
    logic        underrun;

    int n_checks = 0;
    int n_errors = 0;

    bit          q_bit[$];
    logic [23:0] q_addr[$];
    logic [31:0] q_data[$];

    bit          rd_active = 1'b0;
    bit          ready_en = 1'b1;
    int          mem_lat = 2;
    int          acc_limit = 0;
    int          acc_count = 0;
    int          valid_seen = 0;
    bit          mem_busy = 1'b0;
    int          bit_idx = 0;

    spi_flash_responder #(.SYNC_STAGES(2), .READ_CMD(8'h03)) dut (
        .clock(clock), .reset(reset),
        .spi_sck(spi_sck), .spi_ss(spi_ss), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy), .underrun(underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Memory model: accepts requests, checks their address, answers after mem_lat cycles.
    initial begin
        int          lat_cnt;
        logic [23:0] seen_addr;
        lat_cnt = 0;
        seen_addr = 24'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = 32'd0;
        forever begin
            @(posedge clock);
            #1;
            mem_rsp_valid = 1'b0;
            if (reset) begin
                mem_req_ready = 1'b0;
                mem_busy = 1'b0;
            end else begin
                if (mem_req_ready) begin
                    acc_count++;
                    if (q_addr.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL req_unexpected: got addr %h expected no request", seen_addr);
                    end else begin
                        chk("req_addr", {8'd0, seen_addr}, {8'd0, q_addr.pop_front()});
                    end
                    mem_busy = 1'b1;
                    lat_cnt = mem_lat;
                end
                if (mem_busy) begin
                    if (lat_cnt == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_data = (q_data.size() != 0) ? q_data.pop_front() : 32'd0;
                        mem_busy = 1'b0;
                    end else begin
                        lat_cnt--;
                    end
                end
                if (mem_req_valid) valid_seen++;
                mem_req_ready = mem_req_valid && ready_en && (acc_count < acc_limit) && !mem_busy;
                seen_addr = mem_req_addr;
            end
        end
    end

    // MISO monitor: the master samples on each sck rise while selected.
    initial begin
        forever begin
            @(posedge spi_sck);
            if (rd_active) begin
                if (q_bit.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL miso_unexpected: got bit %0d at index %0d expected none", spi_miso, bit_idx);
                end else begin
                    chk($sformatf("miso[%0d]", bit_idx), {31'd0, spi_miso}, {31'd0, q_bit.pop_front()});
                end
                bit_idx++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic wait_half();
        repeat (HALF) @(negedge clock);
    endtask

    task automatic sck_cycle(input bit b);
        spi_mosi = b;
        wait_half();
        spi_sck = 1'b1;
        wait_half();
        spi_sck = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input int n);
        for (int j = 0; j < n; j++) q_bit.push_back(w[31-j]);
    endtask

    // Full transaction; the final data cycle ends with SS rising while sck is high.
    task automatic run_xfer(input logic [7:0] cmd, input logic [23:0] addr, input int ndata,
                            input bit exp_underrun);
        bit_idx = 0;
        spi_ss = 1'b0;
        rd_active = 1'b1;
        wait_half();
        for (int i = 7; i >= 0; i--) sck_cycle(cmd[i]);
        for (int i = 23; i >= 0; i--) sck_cycle(addr[i]);
        for (int j = 0; j < ndata - 1; j++) sck_cycle(1'b0);
        spi_mosi = 1'b0;
        wait_half();
        spi_sck = 1'b1;
        wait_half();
        chk("busy_active", {31'd0, busy}, 32'd1);
        chk("underrun", {31'd0, underrun}, {31'd0, exp_underrun});
        spi_ss = 1'b1;
        rd_active = 1'b0;
        repeat (4) @(negedge clock);
        spi_sck = 1'b0;
        repeat (2 * HALF) @(negedge clock);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("miso_idle", {31'd0, spi_miso}, 32'd0);
        chk("req_valid_idle", {31'd0, mem_req_valid}, 32'd0);
    endtask

    task automatic end_test(input string name, input int exp_acc);
        chk({name, "_accepts"}, acc_count, exp_acc);
        chk({name, "_bits_left"}, q_bit.size(), 32'd0);
        chk({name, "_addr_left"}, q_addr.size(), 32'd0);
    endtask

    task automatic new_test(input int limit);
        acc_count = 0;
        acc_limit = limit;
        valid_seen = 0;
        q_data.delete();
    endtask

    initial begin
        int k;
        reset = 1'b1;
        spi_sck = 1'b0;
        spi_ss = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_miso", {31'd0, spi_miso}, 32'd0);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_req_addr", {8'd0, mem_req_addr}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);

        // Single word read
        new_test(1);
        q_addr.push_back(24'h000100);
        q_data.push_back(32'hDEADBEEF);
        push_word(32'd0, 32);
        push_word(32'hDEADBEEF, 32);
        run_xfer(8'h03, 24'h000100, 32, 1'b0);
        end_test("word", 1);

        // Three-word burst
        new_test(3);
        q_addr.push_back(24'h000100);
        q_addr.push_back(24'h000104);
        q_addr.push_back(24'h000108);
        q_data.push_back(32'hA5A50F0F);
        q_data.push_back(32'h12345678);
        q_data.push_back(32'hCAFEF00D);
        push_word(32'd0, 32);
        push_word(32'hA5A50F0F, 32);
        push_word(32'h12345678, 32);
        push_word(32'hCAFEF00D, 32);
        run_xfer(8'h03, 24'h000100, 96, 1'b0);
        end_test("burst", 3);

        // Unaligned start at the top of the address space wraps to zero
        new_test(2);
        q_addr.push_back(24'hFFFFFC);
        q_addr.push_back(24'h000000);
        q_data.push_back(32'h0BADF00D);
        q_data.push_back(32'h600DCAFE);
        push_word(32'd0, 32);
        push_word(32'h0BADF00D, 32);
        push_word(32'h600DCAFE, 32);
        run_xfer(8'h03, 24'hFFFFFE, 64, 1'b0);
        end_test("wrap", 2);

        // Unknown command: no requests, MISO stays low
        new_test(4);
        push_word(32'd0, 32);
        push_word(32'd0, 24);
        run_xfer(8'h9F, 24'h000100, 24, 1'b0);
        end_test("badcmd", 0);
        chk("badcmd_valid_cycles", valid_seen, 32'd0);

        // Memory stalls, then SS rises before the late response arrives
        new_test(1);
        mem_lat = 300;
        ready_en = 1'b0;
        q_addr.push_back(24'h000200);
        q_data.push_back(32'hBAD0BAD0);
        push_word(32'd0, 32);
        push_word(32'd0, 8);
        fork
            run_xfer(8'h03, 24'h000200, 8, 1'b1);
            begin
                k = 0;
                while (!mem_req_valid && (k < 3000)) begin
                    @(negedge clock);
                    k++;
                end
                chk("stall_req_seen", {31'd0, mem_req_valid}, 32'd1);
                repeat (40) @(negedge clock);
                ready_en = 1'b1;
            end
        join
        repeat (400) @(negedge clock);
        chk("late_rsp_delivered", {31'd0, mem_busy}, 32'd0);
        chk("late_rsp_busy", {31'd0, busy}, 32'd0);
        end_test("abort", 1);
        mem_lat = 2;

        new_test(1);
        q_addr.push_back(24'h000300);
        q_data.push_back(32'h0F1E2D3C);
        push_word(32'd0, 32);
        push_word(32'h0F1E2D3C, 32);
        run_xfer(8'h03, 24'h000300, 32, 1'b0);
        end_test("after_abort", 1);

        // Reset part-way through the address phase
        new_test(0);
        bit_idx = 0;
        push_word(32'd0, 20);
        spi_ss = 1'b0;
        rd_active = 1'b1;
        wait_half();
        for (int i = 7; i >= 0; i--) sck_cycle(1'(8'h03 >> i));
        for (int i = 23; i >= 12; i--) sck_cycle(1'(24'h123456 >> i));
        wait_half();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_miso", {31'd0, spi_miso}, 32'd0);
        chk("mid_reset_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("mid_reset_req_addr", {8'd0, mem_req_addr}, 32'd0);
        chk("mid_reset_underrun", {31'd0, underrun}, 32'd0);
        rd_active = 1'b0;
        spi_ss = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("reset_bits_left", q_bit.size(), 32'd0);

        new_test(1);
        q_addr.push_back(24'h000040);
        q_data.push_back(32'h89ABCDEF);
        push_word(32'd0, 32);
        push_word(32'h89ABCDEF, 32);
        run_xfer(8'h03, 24'h000040, 32, 1'b0);
        end_test("after_reset", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
